// File: rtl/axi_lite_to_apb_bridge_if.sv
// axi_lite_to_apb_bridge_if: AXI4-Lite request/response channels plus the APB bus of the bridge.
// slave = bridge view (AXI slave, APB master); master = environment view.
interface axi_lite_to_apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic [ADDR_WIDTH-1:0] awaddr, araddr, paddr;
    logic [2:0]            awprot, arprot, pprot;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [DATA_WIDTH-1:0] wdata, rdata, pwdata, prdata;
    logic [STRB_WIDTH-1:0] wstrb, pstrb;
    logic [1:0]            bresp, rresp;
    logic                  psel, penable, pwrite, pready, pslverr;
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready, prdata, pready, pslverr,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb
    );
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready, prdata, pready, pslverr,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb
    );
endinterface

// File: rtl/axi_lite_to_apb_bridge.sv
// axi_lite_to_apb_bridge: single-outstanding AXI4-Lite slave to APB master bridge.
// Define APB_TIMEOUT_EN to abort APB accesses stalled for TIMEOUT_CYCLES with SLVERR.
module axi_lite_to_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                     aclk,
    input logic                     aresetn,
    axi_lite_to_apb_bridge_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
    logic [1:0]            r_state, r_resp;
    logic                  r_last_rd, r_write;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic [DATA_WIDTH-1:0] r_pwdata, r_rdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic                  w_idle, w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd, w_resp_done, w_timeout;
    assign w_idle      = r_state == IDLE;
    assign w_wr_pend   = bus.awvalid & bus.wvalid;
    assign w_rd_pend   = bus.arvalid;
    // on contention, grant the type opposite to the previous grant
    assign w_grant_wr  = w_idle & w_wr_pend & (~w_rd_pend | r_last_rd);
    assign w_grant_rd  = w_idle & w_rd_pend & (~w_wr_pend | ~r_last_rd);
    assign w_resp_done = r_write ? bus.bready : bus.rready;
`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    assign w_timeout = (r_state == ACCESS) && !bus.pready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_cnt <= '0;
        else if (r_state == SETUP) r_cnt <= '0;
        else if (r_state == ACCESS && !bus.pready) r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_last_rd <= 1'b1;
            r_write   <= 1'b0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant_wr || w_grant_rd) begin
                    r_state   <= SETUP;
                    r_last_rd <= w_grant_rd;
                    r_write   <= w_grant_wr;
                    r_paddr   <= w_grant_wr ? bus.awaddr : bus.araddr;
                    r_pprot   <= w_grant_wr ? bus.awprot : bus.arprot;
                    r_pstrb   <= w_grant_wr ? bus.wstrb : '0;
                    if (w_grant_wr) r_pwdata <= bus.wdata;
                end
                SETUP: r_state <= ACCESS;
                ACCESS: if (bus.pready || w_timeout) begin
                    r_state <= RESP;
                    r_resp  <= (bus.pslverr || !bus.pready) ? 2'b10 : 2'b00;
                    if (!r_write) r_rdata <= bus.pready ? bus.prdata : '0;
                end
                default: if (w_resp_done) r_state <= IDLE;
            endcase
        end
    end
    assign bus.awready = w_grant_wr;
    assign bus.wready  = w_grant_wr;
    assign bus.arready = w_grant_rd;
    assign bus.psel    = (r_state == SETUP) || (r_state == ACCESS);
    assign bus.penable = r_state == ACCESS;
    assign bus.pwrite  = r_write;
    assign bus.paddr   = r_paddr;
    assign bus.pprot   = r_pprot;
    assign bus.pwdata  = r_pwdata;
    assign bus.pstrb   = r_pstrb;
    assign bus.bvalid  = (r_state == RESP) && r_write;
    assign bus.rvalid  = (r_state == RESP) && !r_write;
    assign bus.bresp   = r_resp;
    assign bus.rresp   = r_resp;
    assign bus.rdata   = r_rdata;
endmodule

// File: doc/axi_lite_to_apb_bridge.md
AXI_LITE_TO_APB_BRIDGE -- requirements
Module: axi_lite_to_apb_bridge

Interface
REQ-001 ADDR_WIDTH, default 32: address width on both the AXI4-Lite and APB sides.
REQ-002 DATA_WIDTH, default 32: data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 TIMEOUT_CYCLES, default 256: APB wait-state limit, used only with APB_TIMEOUT_EN.
REQ-004 aclk  in  1  single clock; all logic rises on posedge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; awready  out  1  AXI write address channel.
REQ-007 wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1; wready  out  1  AXI write data channel.
REQ-008 bresp/bvalid  out  2/1; bready  in  1  AXI write response channel.
REQ-009 araddr/arprot/arvalid  in  ADDR_WIDTH/3/1; arready  out  1  AXI read address channel.
REQ-010 rdata/rresp/rvalid  out  DATA_WIDTH/2/1; rready  in  1  AXI read data channel.
REQ-011 psel/penable/pwrite  out  1/1/1; paddr  out  ADDR_WIDTH; pprot  out  3  APB master control.
REQ-012 pwdata/pstrb  out  DATA_WIDTH/STRB_WIDTH; prdata  in  DATA_WIDTH; pready/pslverr  in  1/1  APB data and response.

Function
REQ-013 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one AXI transaction is outstanding at any time.
REQ-014 IDLE: a write is pending when awvalid and wvalid are both 1; a read is pending when arvalid is 1.
REQ-015 IDLE, write granted: awready and wready are driven 1 together in the same cycle, combinationally; a lone awvalid or lone wvalid is never accepted.
REQ-016 IDLE, read granted: arready is driven 1 combinationally; all ready outputs are 0 in every state other than IDLE.
REQ-017 Arbitration: when both are pending, the bridge grants the type opposite to the last one granted; after reset, the last grant is "read", so the first grant goes to the write.
REQ-018 On handshake, capture addr, prot, wdata and wstrb (pstrb = 0 for reads) and go to SETUP.
REQ-019 SETUP lasts one cycle: psel=1, penable=0, with paddr, pwrite, pprot, pwdata and pstrb valid. Next state is ACCESS.
REQ-020 ACCESS: psel=1, penable=1, all APB outputs held stable; the bridge stays in ACCESS while pready=0.
REQ-021 ACCESS with pready=1: capture prdata (reads), map pslverr to resp (0 -> 2'b00 OKAY, 1 -> 2'b10 SLVERR), drop psel/penable, go to RESP.
REQ-022 RESP: bvalid (write) or rvalid (read) is 1, with bresp/rresp/rdata stable until bready/rready is 1; then return to IDLE.
REQ-023 Minimum latency: AXI handshake in cycle N -> psel in N+1 -> penable in N+2 -> bvalid/rvalid in N+3 (zero wait states).
REQ-024 An AXI handshake accepted in the cycle the bridge enters IDLE is legal, giving back-to-back throughput of 4 cycles per transaction.
REQ-025 Outside SETUP/ACCESS: psel=0 and penable=0; paddr, pwdata and pstrb hold their last values; rdata holds its last value.

Reset
REQ-026 When aresetn=0, the bridge immediately goes to IDLE and drives psel, penable, pwrite, bvalid and rvalid to 0, bresp and rresp to 0, and paddr, pprot, pwdata, pstrb and rdata to 0; the last grant is set to "read".
REQ-027 Reset asserted mid-SETUP, ACCESS or RESP aborts the transaction with no response issued; after deassertion, the bridge waits for new AXI requests.

Configuration
REQ-028 APB_TIMEOUT_EN defined: a counter clears on SETUP and counts ACCESS cycles with pready=0; when it reaches TIMEOUT_CYCLES, the bridge drops psel/penable, goes to RESP with resp=2'b10 and rdata=0, and ignores any later pready.
REQ-029 APB_TIMEOUT_EN undefined: there is no counter, ACCESS waits indefinitely for pready, and TIMEOUT_CYCLES has no effect.

Verification
REQ-030 Write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, pready=1 at once -> paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF; psel at N+1, penable at N+2, bvalid at N+3 with bresp=00.
REQ-031 Read: araddr=0x24, 3 wait states, prdata=0x12345678 -> rvalid at N+6 with rdata=0x12345678 and rresp=00, and pstrb=0 throughout.
REQ-032 Write with pslverr=1 -> bresp=2'b10; a read with pslverr=1 -> rresp=2'b10.
REQ-033 After reset, AW+W and AR all valid in the same cycle -> write served first, then read; with all three held valid, grants alternate W, R, W, R.
REQ-034 bready held 0 for 5 cycles -> bvalid and bresp stable, arready=0, psel=0; on bready=1, the bridge returns to IDLE next cycle.
REQ-035 APB_TIMEOUT_EN with pready stuck 0 -> SLVERR after exactly 256 ACCESS cycles; aresetn low mid-ACCESS -> psel=0 immediately and no bvalid/rvalid issued.
